// File: rtl/irq_ctrl8_pkg.sv
// Shared types and constants for the eight-source interrupt request controller.
package irq_ctrl8_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ASSERT,
    SERVICE
  } state_e;

  localparam int NUM_SRC      = 8;
  localparam int SPURIOUS_OFS = 8;

endpackage

// File: rtl/irq_ctrl8_if.sv
// Request, mask, host handshake and cascade signals of irq_ctrl8, bundled as one interface.
interface irq_ctrl8_if;
  import irq_ctrl8_pkg::*;

  logic [NUM_SRC-1:0] req_N;
  logic               ei_N;
  logic               mask_we;
  logic [NUM_SRC-1:0] mask_wdata;
  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] in_service;
  logic               irq_N;
  logic               int_ack;
  logic [7:0]         vector;
  logic               vec_valid;
  logic               eoi;
  logic               gs_N;
  logic               eo_N;

  modport master (
    output req_N, ei_N, mask_we, mask_wdata, int_ack, eoi,
    input  mask, pending, in_service, irq_N, vector, vec_valid, gs_N, eo_N
  );

  modport slave (
    input  req_N, ei_N, mask_we, mask_wdata, int_ack, eoi,
    output mask, pending, in_service, irq_N, vector, vec_valid, gs_N, eo_N
  );

endinterface

// File: rtl/irq_ctrl8_prio_enc.sv
// Positive-logic 8-to-3 priority encoder; the highest set bit wins.
module prio_enc8 (
  input  logic [7:0] i_eligible,
  output logic [2:0] o_idx,
  output logic       o_any
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    o_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (i_eligible[i]) o_idx = 3'(i);
    end
    o_any = |i_eligible;
  end

endmodule

// File: rtl/irq_ctrl8.sv
// Interrupt request controller: request capture, mask, cascade enable and an IDLE/ASSERT/SERVICE handshake.
module irq_ctrl8
  import irq_ctrl8_pkg::*;
#(
  parameter bit         EDGE_MODE = 1'b1,
  parameter logic [7:0] VEC_BASE  = 8'h20
) (
  input  logic        clk,
  input  logic        rst_n,
  irq_ctrl8_if.slave  bus
);

  state_e             r_state, w_state_nxt;
  logic [NUM_SRC-1:0] r_req_q, r_pending, r_mask, r_in_service;
  logic [NUM_SRC-1:0] w_eligible, w_clr, w_set, w_pending_nxt;
  logic [2:0]         w_idx;
  logic               w_any, w_take, w_spur;
  logic               r_irq_n, r_vec_valid;
  logic [7:0]         r_vector;

  assign w_eligible = r_pending & ~r_mask & {NUM_SRC{~bus.ei_N}};

  prio_enc8 u_enc (
    .i_eligible (w_eligible),
    .o_idx      (w_idx),
    .o_any      (w_any)
  );

  // w_any can only be set while ei_N is low, so both cascade outputs read 1 when ei_N is high.
  assign bus.gs_N = ~w_any;
  assign bus.eo_N = bus.ei_N | w_any;

  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_spur      = 1'b0;
    unique case (r_state)
      IDLE:    if (w_any) w_state_nxt = ASSERT;
      ASSERT: begin
        if (bus.int_ack) begin
          if (w_any) begin
            w_take      = 1'b1;
            w_state_nxt = SERVICE;
          end else begin
            w_spur      = 1'b1;
            w_state_nxt = IDLE;
          end
        end else if (!w_any) begin
          w_state_nxt = IDLE;
        end
      end
      SERVICE: if (bus.eoi) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // A fresh edge in the acknowledge cycle overrides the clear, so that request is not lost.
  always_comb begin
    w_clr = '0;
    if (w_take) w_clr[w_idx] = 1'b1;
    w_set = r_req_q & ~bus.req_N;
    if (EDGE_MODE) w_pending_nxt = (r_pending & ~w_clr) | w_set;
    else           w_pending_nxt = ~bus.req_N & ~w_clr;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_req_q      <= '1;
      r_pending    <= '0;
      r_mask       <= '1;
      r_in_service <= '0;
      r_irq_n      <= 1'b1;
      r_vector     <= 8'h00;
      r_vec_valid  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_req_q     <= bus.req_N;
      r_pending   <= w_pending_nxt;
      r_irq_n     <= (w_state_nxt != ASSERT);
      r_vec_valid <= w_take | w_spur;
      if (bus.mask_we) r_mask <= bus.mask_wdata;
      if (w_take) begin
        r_vector     <= VEC_BASE + {5'd0, w_idx};
        r_in_service <= w_clr;
      end else if (w_spur) begin
        r_vector     <= VEC_BASE + 8'(SPURIOUS_OFS);
      end else if (r_state == SERVICE && bus.eoi) begin
        r_in_service <= '0;
      end
    end
  end

  assign bus.mask       = r_mask;
  assign bus.pending    = r_pending;
  assign bus.in_service = r_in_service;
  assign bus.irq_N      = r_irq_n;
  assign bus.vector     = r_vector;
  assign bus.vec_valid  = r_vec_valid;

endmodule
